// File: rtl/heart_rate_meter_if.sv
// rtl/heart_rate_meter_if.sv - sensor-side and result signals of the heart-rate meter
interface heart_rate_meter_if;
   logic       pulse_in;
   logic [7:0] bpm;
   logic       bpm_valid;
   logic       beat;
   logic       no_signal;

   modport master (
      output pulse_in,
      input  bpm, bpm_valid, beat, no_signal
   );

   modport slave (
      input  pulse_in,
      output bpm, bpm_valid, beat, no_signal
   );
endinterface

// File: rtl/heart_rate_meter.sv
// rtl/heart_rate_meter.sv - pulse sensor to beats-per-minute converter
// Synchronise/debounce, measure beat period in ms, divide 60000 by it.
module heart_rate_meter #(
   parameter int CLKS_PER_MS     = 50000,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int MIN_PERIOD_MS   = 250,
   parameter int MAX_PERIOD_MS   = 3000
) (
   input logic               clk,
   input logic               reset,
   heart_rate_meter_if.slave hr
);
   localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_MS - 1);
   localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [11:0]   MIN_MS   = 12'(MIN_PERIOD_MS);
   localparam logic [11:0]   MAX_MS   = 12'(MAX_PERIOD_MS);
   localparam logic [15:0]   DIVIDEND = 16'd60000;

   typedef enum logic [1:0] {WAIT_FIRST, MEASURE, DIVIDE} state_t;

   logic          sync1_q, sync2_q;
   logic          filt_q, filt_prev_q;
   logic [DW-1:0] db_cnt_q;
   logic [PW-1:0] pre_q;
   logic [11:0]   ms_count_q;
   logic [11:0]   period_q;
   logic [11:0]   rem_q;
   logic [15:0]   quo_q;
   logic [4:0]    div_cnt_q;
   state_t        state_q;
   logic [7:0]    bpm_q;
   logic          bpm_valid_q, beat_q, no_signal_q;

   logic          ms_tick, cand;
   logic [12:0]   trial;
   logic          div_ge;
   logic [11:0]   rem_d;

   assign ms_tick = (pre_q == PRE_LAST);
   assign cand    = filt_q & ~filt_prev_q;
   assign trial   = {rem_q, quo_q[15]};
   assign div_ge  = (trial >= {1'b0, period_q});
   assign rem_d   = div_ge ? 12'(trial - {1'b0, period_q}) : trial[11:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         filt_q      <= 1'b0;
         filt_prev_q <= 1'b0;
         db_cnt_q    <= '0;
         pre_q       <= '0;
      end else begin
         sync1_q     <= hr.pulse_in;
         sync2_q     <= sync1_q;
         filt_prev_q <= filt_q;
         // The level only follows the synced input after an unbroken run of disagreement.
         if (sync2_q == filt_q) begin
            db_cnt_q <= '0;
         end else if (db_cnt_q == DB_LAST) begin
            filt_q   <= sync2_q;
            db_cnt_q <= '0;
         end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
         end
         pre_q <= ms_tick ? '0 : pre_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= WAIT_FIRST;
         ms_count_q  <= '0;
         period_q    <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         div_cnt_q   <= '0;
         bpm_q       <= '0;
         bpm_valid_q <= 1'b0;
         beat_q      <= 1'b0;
         no_signal_q <= 1'b1;
      end else begin
         beat_q      <= 1'b0;
         bpm_valid_q <= 1'b0;
         if (ms_tick && (ms_count_q < MAX_MS)) begin
            ms_count_q <= ms_count_q + 1'b1;
         end
         case (state_q)
            WAIT_FIRST: begin
               if (cand) begin
                  beat_q     <= 1'b1;
                  ms_count_q <= '0;
                  state_q    <= MEASURE;
               end
            end
            MEASURE: begin
               // Timeout is checked first so a coincident edge is dropped.
               if (ms_count_q >= MAX_MS) begin
                  bpm_q       <= '0;
                  bpm_valid_q <= 1'b1;
                  no_signal_q <= 1'b1;
                  state_q     <= WAIT_FIRST;
               end else if (cand && (ms_count_q >= MIN_MS)) begin
                  beat_q     <= 1'b1;
                  period_q   <= ms_count_q;
                  ms_count_q <= '0;
                  rem_q      <= '0;
                  quo_q      <= DIVIDEND;
                  div_cnt_q  <= '0;
                  state_q    <= DIVIDE;
               end
            end
            DIVIDE: begin
               if (div_cnt_q != 5'd16) begin
                  rem_q     <= rem_d;
                  quo_q     <= {quo_q[14:0], div_ge};
                  div_cnt_q <= div_cnt_q + 1'b1;
               end else begin
                  bpm_q       <= (quo_q[15:8] != 8'd0) ? 8'hFF : quo_q[7:0];
                  bpm_valid_q <= 1'b1;
                  no_signal_q <= 1'b0;
                  state_q     <= MEASURE;
               end
            end
            default: state_q <= WAIT_FIRST;
         endcase
      end
   end

   assign hr.bpm       = bpm_q;
   assign hr.bpm_valid = bpm_valid_q;
   assign hr.beat      = beat_q;
   assign hr.no_signal = no_signal_q;
endmodule
